// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared helpers for the multi-channel debouncer.
//   - clog2max(a, b): width needed to hold any value 0..max(a, b).
//   - DEF_* localparams: default timing and the counter width it implies.
// -----------------------------------------------------------------------------
package debounce_pkg;

   // Width of a counter that must reach max(a, b) inclusive.
   function automatic int clog2max(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

   localparam int DEF_TIME      = 5;
   localparam int DEF_HOLD_TIME = 0;
   localparam int DEF_CNT_W     = clog2max(DEF_TIME, DEF_HOLD_TIME);

endpackage : debounce_pkg

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
//   One debounce channel: two-flop synchroniser, tick-qualified debounce
//   counter, optional hold timer and registered one-clock event pulses.
//
//   Ports
//     clk      in  system clock
//     rst      in  synchronous, active-high reset
//     sig_in   in  raw asynchronous input
//     ms_tck   in  one-clock millisecond strobe
//     sig_out  out debounced level
//     rise     out one-clock pulse when sig_out goes 0->1
//     fall     out one-clock pulse when sig_out goes 1->0
//     held     out one-clock pulse after sig_out stays at ACTIVE for HOLD_TIME ticks
// -----------------------------------------------------------------------------
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int   TIME      = DEF_TIME,
   parameter int   HOLD_TIME = DEF_HOLD_TIME,
   parameter logic ACTIVE    = 1'b1,
   parameter logic RST_VAL   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   input  logic ms_tck,
   output logic sig_out,
   output logic rise,
   output logic fall,
   output logic held
);

   localparam int CW = clog2max(TIME, HOLD_TIME);
   localparam logic [CW-1:0] TIME_LAST = CW'(TIME - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;
   logic          upd;

   // High on the single cycle in which sig_out takes the synchronised value.
   assign upd = (sync2 != sig_out) && ms_tck && (cnt == TIME_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= RST_VAL;
         sync2   <= RST_VAL;
         sig_out <= RST_VAL;
         cnt     <= '0;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep sync1->sync2 a true two-stage
         // pipeline regardless of statement order.
         sync1 <= sig_in;
         sync2 <= sync1;
         // NOTE: pulses default low every cycle so each lasts exactly one clock.
         rise  <= 1'b0;
         fall  <= 1'b0;
         if (sync2 == sig_out) begin
            // Any bounce back to the current level restarts qualification.
            cnt <= '0;
         end else if (upd) begin
            sig_out <= sync2;
            cnt     <= '0;
            rise    <= sync2;
            fall    <= ~sync2;
         end else if (ms_tck) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   generate
      if (HOLD_TIME > 0) begin : g_hold
         localparam logic [CW-1:0] HOLD_MAX  = CW'(HOLD_TIME);
         localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TIME - 1);

         logic [CW-1:0] hcnt;

         always_ff @(posedge clk) begin
            if (rst) begin
               hcnt <= '0;
               held <= 1'b0;
            end else begin
               held <= 1'b0;
               if (upd || (sig_out != ACTIVE)) begin
                  hcnt <= '0;
               end else if (ms_tck && (hcnt != HOLD_MAX)) begin
                  // Saturation at HOLD_MAX guarantees one pulse per press.
                  hcnt <= hcnt + 1'b1;
                  if (hcnt == HOLD_LAST) held <= 1'b1;
               end
            end
         end
      end else begin : g_no_hold
         assign held = 1'b0;
      end
   endgenerate

endmodule : debounce_chan

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//   CH independent debounce channels sharing clock, reset and ms tick.
//
//   Ports
//     clk      in  system clock
//     rst      in  synchronous, active-high reset
//     sig_in   in  [CH] raw asynchronous inputs
//     ms_tck   in  one-clock millisecond strobe, synchronous to clk
//     sig_out  out [CH] debounced levels
//     rise     out [CH] one-clock pulse: sig_out went 0->1
//     fall     out [CH] one-clock pulse: sig_out went 1->0
//     held     out [CH] one-clock pulse: sig_out held at ACTIVE for HOLD_TIME ticks
// -----------------------------------------------------------------------------
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int   CH        = 4,
   parameter int   TIME      = DEF_TIME,
   parameter int   HOLD_TIME = DEF_HOLD_TIME,
   parameter logic ACTIVE    = 1'b1,
   parameter logic RST_VAL   = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] sig_in,
   input  logic          ms_tck,
   output logic [CH-1:0] sig_out,
   output logic [CH-1:0] rise,
   output logic [CH-1:0] fall,
   output logic [CH-1:0] held
);

   generate
      for (genvar i = 0; i < CH; i++) begin : g_chan
         debounce_chan #(
            .TIME      (TIME),
            .HOLD_TIME (HOLD_TIME),
            .ACTIVE    (ACTIVE),
            .RST_VAL   (RST_VAL)
         ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .sig_in  (sig_in[i]),
            .ms_tck  (ms_tck),
            .sig_out (sig_out[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .held    (held[i])
         );
      end
   endgenerate

endmodule : debounce_multi

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
//   Directed scenarios plus a randomized phase for debounce_multi, compared
//   every cycle against a behavioural model and at key points against fixed
//   expected latencies and pulse counts.
// -----------------------------------------------------------------------------
module tb_debounce_multi;

   localparam int   CH        = 4;
   localparam int   TIME      = 5;
   localparam int   HOLD_TIME = 8;
   localparam logic ACTIVE    = 1'b1;
   localparam logic RST_VAL   = 1'b1;

   logic          clk = 1'b0;
   logic          rst;
   logic [CH-1:0] sig_in;
   logic          ms_tck;
   logic [CH-1:0] sig_out, rise, fall, held;

   always #10 clk = ~clk;

   debounce_multi #(
      .CH(CH), .TIME(TIME), .HOLD_TIME(HOLD_TIME), .ACTIVE(ACTIVE), .RST_VAL(RST_VAL)
   ) dut (
      .clk(clk), .rst(rst), .sig_in(sig_in), .ms_tck(ms_tck),
      .sig_out(sig_out), .rise(rise), .fall(fall), .held(held)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- behavioural reference ----------------
   // seen     : raw input delayed by two clocks
   // m_run    : consecutive ticks observed while seen differs from the level
   // m_press  : ticks elapsed since the level settled at ACTIVE (unbounded)
   logic [CH-1:0] m_d1, m_d2, m_out, m_rise, m_fall, m_held;
   int            m_run   [CH];
   int            m_press [CH];

   always @(posedge clk) begin
      if (rst) begin
         m_d1 <= {CH{RST_VAL}};
         m_d2 <= {CH{RST_VAL}};
         m_out <= {CH{RST_VAL}};
         m_rise <= '0; m_fall <= '0; m_held <= '0;
         for (int c = 0; c < CH; c++) begin
            m_run[c]   <= 0;
            m_press[c] <= 0;
         end
      end else begin
         m_d1 <= sig_in;
         m_d2 <= m_d1;
         for (int c = 0; c < CH; c++) begin
            m_rise[c] <= 1'b0;
            m_fall[c] <= 1'b0;
            m_held[c] <= 1'b0;
            if (m_d2[c] == m_out[c]) begin
               m_run[c] <= 0;
               if (m_out[c] != ACTIVE) m_press[c] <= 0;
               else if (ms_tck) begin
                  m_press[c] <= m_press[c] + 1;
                  if (m_press[c] + 1 == HOLD_TIME) m_held[c] <= 1'b1;
               end
            end else if (ms_tck && (m_run[c] + 1 >= TIME)) begin
               m_out[c]   <= m_d2[c];
               m_rise[c]  <= m_d2[c];
               m_fall[c]  <= ~m_d2[c];
               m_run[c]   <= 0;
               m_press[c] <= 0;
            end else begin
               if (ms_tck) m_run[c] <= m_run[c] + 1;
               if (m_out[c] != ACTIVE) m_press[c] <= 0;
               else if (ms_tck) begin
                  m_press[c] <= m_press[c] + 1;
                  if (m_press[c] + 1 == HOLD_TIME) m_held[c] <= 1'b1;
               end
            end
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   int n_rise [CH];
   int n_fall [CH];
   int n_held [CH];
   int ticks     = 0;
   int tick_mode = 0;   // 0: every 3 clk, 1: tied high, 2: random
   int phase     = 0;

   task automatic compare_all();
      check("sig_out", sig_out, m_out);
      check("rise",    rise,    m_rise);
      check("fall",    fall,    m_fall);
      check("held",    held,    m_held);
      for (int c = 0; c < CH; c++) begin
         if (rise[c] === 1'b1) n_rise[c]++;
         if (fall[c] === 1'b1) n_fall[c]++;
         if (held[c] === 1'b1) n_held[c]++;
      end
   endtask

   // One clock: count the tick sampled at this edge, drive the next ms_tck
   // one time unit after the edge, compare on the falling edge.
   task automatic cyc(input int n);
      logic tk;
      for (int k = 0; k < n; k++) begin
         tk = ms_tck && !rst;
         @(posedge clk);
         if (tk) ticks++;
         #1;
         case (tick_mode)
            0: begin
               phase  = (phase + 1) % 3;
               ms_tck = (phase == 0);
            end
            1:       ms_tck = 1'b1;
            default: ms_tck = ($urandom_range(0, 2) == 0);
         endcase
         @(negedge clk);
         compare_all();
      end
   endtask

   int t0, t1, k, base;

   initial begin
      for (int c = 0; c < CH; c++) begin
         n_rise[c] = 0; n_fall[c] = 0; n_held[c] = 0;
      end
      rst    = 1'b1;
      sig_in = 4'hF;
      ms_tck = 1'b0;

      // 1: reset for two clocks, then release with inputs high
      cyc(2);
      check("t1_rst_out", sig_out, 4'hF);
      rst = 1'b0;
      cyc(3);
      check("t1_release_out", sig_out, 4'hF);
      check_int("t1_no_rise", n_rise[0] + n_rise[1] + n_rise[2] + n_rise[3], 0);
      check_int("t1_no_fall", n_fall[0] + n_fall[1] + n_fall[2] + n_fall[3], 0);

      // 2: ch0 bounces every 5 ns for 45 ns, then returns high
      fork
         cyc(4);
         begin
            #2;
            repeat (9) begin
               #5 sig_in[0] = ~sig_in[0];
            end
            #1 sig_in[0] = 1'b1;
         end
      join
      cyc(20);
      check_int("t2_no_fall0", n_fall[0], 0);
      check("t2_out", sig_out, 4'hF);

      // 3: ch1 steps low and stays
      sig_in[1] = 1'b0;
      cyc(2);
      t0 = ticks;
      k  = 0;
      while (fall[1] !== 1'b1 && k < 60) begin cyc(1); k++; end
      check_int("t3_fall1_seen", int'(fall[1]), 1);
      check_int("t3_ticks_to_fall", ticks - t0, TIME);
      check("t3_out", sig_out, 4'hD);
      cyc(5);
      check_int("t3_fall1_count", n_fall[1], 1);

      // 4: ch2 low, then high and held for 20+ ticks
      sig_in[2] = 1'b0;
      k = 0;
      while (fall[2] !== 1'b1 && k < 60) begin cyc(1); k++; end
      check_int("t4_fall2_seen", int'(fall[2]), 1);
      base = n_held[2];
      sig_in[2] = 1'b1;
      cyc(2);
      t0 = ticks;
      k  = 0;
      while (rise[2] !== 1'b1 && k < 60) begin cyc(1); k++; end
      check_int("t4_rise2_seen", int'(rise[2]), 1);
      check_int("t4_ticks_to_rise", ticks - t0, TIME);
      t1 = ticks;
      k  = 0;
      while (held[2] !== 1'b1 && k < 90) begin cyc(1); k++; end
      check_int("t4_held2_seen", int'(held[2]), 1);
      check_int("t4_ticks_to_held", ticks - t1, HOLD_TIME);
      cyc(60);
      check_int("t4_held2_once", n_held[2] - base, 1);

      // 5: ch3 low, reset after three ticks discards partial count
      base = n_fall[3];
      sig_in[3] = 1'b0;
      cyc(2);
      t0 = ticks;
      k  = 0;
      while (ticks - t0 < 3 && k < 30) begin cyc(1); k++; end
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      check("t5_out_after_rst", sig_out, 4'hF);
      check_int("t5_no_fall3", n_fall[3] - base, 0);
      cyc(2);
      t0 = ticks;
      k  = 0;
      while (fall[3] !== 1'b1 && k < 60) begin cyc(1); k++; end
      check_int("t5_fall3_seen", int'(fall[3]), 1);
      check_int("t5_ticks_to_fall", ticks - t0, TIME);

      // 6: ms_tck tied high, ch0 step 1->0 takes TIME+2 clocks
      tick_mode = 1;
      sig_in    = 4'hF;
      cyc(20);
      check("t6_settled", sig_out, 4'hF);
      sig_in[0] = 1'b0;
      k = 0;
      while (fall[0] !== 1'b1 && k < 30) begin cyc(1); k++; end
      check_int("t6_latency", k, TIME + 2);
      check_int("t6_out0", int'(sig_out[0]), 0);

      // Randomized phase: sparse input flips, random ticks, occasional reset
      tick_mode = 2;
      repeat (1200) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 15) == 0) sig_in[c] = ~sig_in[c];
         rst = ($urandom_range(0, 249) == 0);
         cyc(1);
      end
      rst = 1'b0;
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_debounce_multi
